vga_sync_generator: RTL and testbench

- Timing front-end of the VGA controller, directly upstream of the pixel generator.
- Divides the system clock into a pixel rate.
- Runs horizontal and vertical position counters.
- Drives xpixel, ypixel and video into the pixel generator, and hsync/vsync to the connector.
- Default timing is 640x480 at 60 Hz (800x525 total) from a 100 MHz clk with CLK_DIV=4.

---
 rtl/vga_sync_generator.sv | 164 ++++++++++++++++
 tb/tb_vga_sync_generator.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_generator.sv
// VGA timing front-end: divides clk to the pixel rate, runs h/v position counters and
// drives registered xpixel/ypixel/video/hsync/vsync. Macro VGA_FRAME_CNT_EN adds frame_count.
module vga_sync_generator #(
    parameter int H_display = 640,
    parameter int H_front   = 16,
    parameter int H_sync    = 96,
    parameter int H_back    = 48,
    parameter int V_display = 480,
    parameter int V_front   = 10,
    parameter int V_sync    = 2,
    parameter int V_back    = 33,
    parameter int CLK_DIV   = 4,
    parameter int SYNC_POL  = 0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        pixel_tick,
    output logic [15:0] xpixel,
    output logic [15:0] ypixel,
    output logic        video,
    output logic        hsync,
    output logic        vsync,
`ifdef VGA_FRAME_CNT_EN
    output logic        frame_start,
    output logic [15:0] frame_count
`else
    output logic        frame_start
`endif
);

    localparam int H_TOTAL = H_display + H_front + H_sync + H_back;
    localparam int V_TOTAL = V_display + V_front + V_sync + V_back;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_VIS  = 16'(H_display);
    localparam logic [15:0] V_VIS  = 16'(V_display);
    localparam logic [15:0] HS_BEG = 16'(H_display + H_front);
    localparam logic [15:0] HS_END = 16'(H_display + H_front + H_sync);
    localparam logic [15:0] VS_BEG = 16'(V_display + V_front);
    localparam logic [15:0] VS_END = 16'(V_display + V_front + V_sync);
    localparam logic SYNC_ACT = (SYNC_POL != 0) ? 1'b1 : 1'b0;

    function automatic logic in_window(input logic [15:0] pos,
                                       input logic [15:0] lo,
                                       input logic [15:0] hi);
        return (pos >= lo) && (pos < hi);
    endfunction

    function automatic logic sync_level(input logic active);
        return active ? SYNC_ACT : ~SYNC_ACT;
    endfunction

    logic [DIV_W-1:0] div_q, div_d;
    logic [15:0]      hcount_q, hcount_d;
    logic [15:0]      vcount_q, vcount_d;
    logic             pixel_tick_q, pixel_tick_d;
    logic             video_q, video_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             frame_start_q, frame_start_d;
    logic             div_wrap_s;
    logic             h_wrap_s;
    logic             v_wrap_s;

    // Next-state of divider and position counters.
    always_comb begin
        div_d      = div_q;
        hcount_d   = hcount_q;
        vcount_d   = vcount_q;
        div_wrap_s = (div_q == DIV_LAST);
        h_wrap_s   = div_wrap_s && (hcount_q == H_LAST);
        v_wrap_s   = h_wrap_s && (vcount_q == V_LAST);

        if (div_wrap_s) begin
            div_d = '0;
        end else begin
            div_d = div_q + {{(DIV_W-1){1'b0}}, 1'b1};
        end

        if (!div_wrap_s) begin
            hcount_d = hcount_q;
        end else if (h_wrap_s) begin
            hcount_d = 16'd0;
        end else begin
            hcount_d = hcount_q + 16'd1;
        end

        if (!h_wrap_s) begin
            vcount_d = vcount_q;
        end else if (v_wrap_s) begin
            vcount_d = 16'd0;
        end else begin
            vcount_d = vcount_q + 16'd1;
        end
    end

    // Outputs are decoded from the next counter values so they register on the same edge.
    always_comb begin
        pixel_tick_d  = (div_d == '0);
        video_d       = (hcount_d < H_VIS) && (vcount_d < V_VIS);
        hsync_d       = sync_level(in_window(hcount_d, HS_BEG, HS_END));
        vsync_d       = sync_level(in_window(vcount_d, VS_BEG, VS_END));
        frame_start_d = v_wrap_s;
    end

    // Counter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q         <= '0;
            hcount_q      <= 16'd0;
            vcount_q      <= 16'd0;
            pixel_tick_q  <= 1'b1;
            video_q       <= 1'b1;
            hsync_q       <= ~SYNC_ACT;
            vsync_q       <= ~SYNC_ACT;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            pixel_tick_q  <= pixel_tick_d;
            video_q       <= video_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pixel_tick  = pixel_tick_q;
    assign xpixel      = hcount_q;
    assign ypixel      = vcount_q;
    assign video       = video_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_count_q, frame_count_d;

    // Frames completed; bumps on the edge that raises frame_start, wraps naturally.
    always_comb begin
        if (frame_start_d) begin
            frame_count_d = frame_count_q + 16'd1;
        end else begin
            frame_count_d = frame_count_q;
        end
    end

    // Frame counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count_q <= 16'd0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_vga_sync_generator.sv
// Directed bench for vga_sync_generator on a reduced 15x8 timing: instance A (CLK_DIV=4,
// active-low sync) and instance B (CLK_DIV=1, active-high sync) share clock and reset.
module tb_vga_sync_generator;

    // Reduced timing: H 8+2+3+2=15 (hsync x=10..12), V 4+1+2+1=8 (vsync y=5..6).
    localparam int HT = 15;
    localparam int VT = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic        a_tick, a_video, a_hs, a_vs, a_fs;
    logic [15:0] a_x, a_y;
    logic        b_tick, b_video, b_hs, b_vs, b_fs;
    logic [15:0] b_x, b_y;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] a_fc, b_fc;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vga_sync_generator #(
        .H_display(8), .H_front(2), .H_sync(3), .H_back(2),
        .V_display(4), .V_front(1), .V_sync(2), .V_back(1),
        .CLK_DIV(4), .SYNC_POL(0)
    ) u_a (
        .clk(clk), .reset(reset), .pixel_tick(a_tick), .xpixel(a_x), .ypixel(a_y),
        .video(a_video), .hsync(a_hs), .vsync(a_vs),
`ifdef VGA_FRAME_CNT_EN
        .frame_start(a_fs), .frame_count(a_fc)
`else
        .frame_start(a_fs)
`endif
    );

    vga_sync_generator #(
        .H_display(8), .H_front(2), .H_sync(3), .H_back(2),
        .V_display(4), .V_front(1), .V_sync(2), .V_back(1),
        .CLK_DIV(1), .SYNC_POL(1)
    ) u_b (
        .clk(clk), .reset(reset), .pixel_tick(b_tick), .xpixel(b_x), .ypixel(b_y),
        .video(b_video), .hsync(b_hs), .vsync(b_vs),
`ifdef VGA_FRAME_CNT_EN
        .frame_start(b_fs), .frame_count(b_fc)
`else
        .frame_start(b_fs)
`endif
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(3);
        checks++;
        if ({a_x, a_y} !== 32'd0 || a_video !== 1'b1 || a_hs !== 1'b1 || a_vs !== 1'b1 ||
            a_tick !== 1'b1 || a_fs !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: x=%0d y=%0d v=%b hs=%b vs=%b tick=%b fs=%b, want 0 0 1 1 1 1 0",
                     a_x, a_y, a_video, a_hs, a_vs, a_tick, a_fs);
        end
        checks++;
        if ({b_x, b_y} !== 32'd0 || b_video !== 1'b1 || b_hs !== 1'b0 || b_vs !== 1'b0 ||
            b_tick !== 1'b1 || b_fs !== 1'b0) begin
            errors++;
            $display("FAIL reset_b: x=%0d y=%0d v=%b hs=%b vs=%b tick=%b fs=%b, want 0 0 1 0 0 1 0",
                     b_x, b_y, b_video, b_hs, b_vs, b_tick, b_fs);
        end
`ifdef VGA_FRAME_CNT_EN
        checks++;
        if (a_fc !== 16'd0 || b_fc !== 16'd0) begin
            errors++;
            $display("FAIL reset_fc: a=%0d b=%0d, want 0 0", a_fc, b_fc);
        end
`endif
        reset = 1'b0;
        step(1);
        checks++;
        if (a_x !== 16'd0 || a_tick !== 1'b0 || b_x !== 16'd1 || b_tick !== 1'b1) begin
            errors++;
            $display("FAIL release_1clk: a_x=%0d a_tick=%b b_x=%0d b_tick=%b, want 0 0 1 1",
                     a_x, a_tick, b_x, b_tick);
        end
        step(2);
        checks++;
        if (a_x !== 16'd0) begin
            errors++;
            $display("FAIL release_3clk: a_x=%0d, want 0", a_x);
        end
        step(1);
        checks++;
        if (a_x !== 16'd1 || a_tick !== 1'b1) begin
            errors++;
            $display("FAIL release_4clk: a_x=%0d a_tick=%b, want 1 1", a_x, a_tick);
        end
    endtask

    // Free-run from n=5 to n=1444 clks after release: 3 frames of A, 12 of B.
    task automatic test_free_run();
        int p, x, y, hs_low_line0, fs_count, last_fs, max_x;
        logic ev, ehs, evs, efs;
        hs_low_line0 = 0;
        fs_count     = 0;
        last_fs      = 0;
        max_x        = 0;
        for (int n = 5; n <= 1444; n++) begin
            step(1);
            p   = n / 4;
            x   = p % HT;
            y   = (p / HT) % VT;
            ev  = (x < 8) && (y < 4);
            ehs = !((x >= 10) && (x < 13));
            evs = !((y >= 5) && (y < 7));
            efs = (n % 4 == 0) && (p > 0) && (p % (HT * VT) == 0);
            checks++;
            if (a_x !== x[15:0] || a_y !== y[15:0] || a_video !== ev || a_hs !== ehs ||
                a_vs !== evs || a_tick !== (n % 4 == 0) || a_fs !== efs) begin
                errors++;
                $display("FAIL run_a n=%0d: x=%0d y=%0d v=%b hs=%b vs=%b tick=%b fs=%b, want %0d %0d %b %b %b %b %b",
                         n, a_x, a_y, a_video, a_hs, a_vs, a_tick, a_fs,
                         x, y, ev, ehs, evs, (n % 4 == 0), efs);
            end
            if (n < 60 && a_hs === 1'b0) hs_low_line0++;
            if (a_fs === 1'b1) begin
                if (fs_count > 0) begin
                    checks++;
                    if (n - last_fs !== 480) begin
                        errors++;
                        $display("FAIL frame_period: got %0d clks, want 480", n - last_fs);
                    end
                end
                fs_count++;
                last_fs = n;
            end
            if (int'(a_x) > max_x) max_x = int'(a_x);
`ifdef VGA_FRAME_CNT_EN
            checks++;
            if (a_fc !== 16'(n / 480)) begin
                errors++;
                $display("FAIL frame_count_a n=%0d: got %0d, want %0d", n, a_fc, n / 480);
            end
`endif
            x   = n % HT;
            y   = (n / HT) % VT;
            ev  = (x < 8) && (y < 4);
            ehs = (x >= 10) && (x < 13);
            evs = (y >= 5) && (y < 7);
            efs = (n % (HT * VT) == 0);
            checks++;
            if (b_x !== x[15:0] || b_y !== y[15:0] || b_video !== ev || b_hs !== ehs ||
                b_vs !== evs || b_tick !== 1'b1 || b_fs !== efs) begin
                errors++;
                $display("FAIL run_b n=%0d: x=%0d y=%0d v=%b hs=%b vs=%b tick=%b fs=%b, want %0d %0d %b %b %b 1 %b",
                         n, b_x, b_y, b_video, b_hs, b_vs, b_tick, b_fs, x, y, ev, ehs, evs, efs);
            end
`ifdef VGA_FRAME_CNT_EN
            checks++;
            if (b_fc !== 16'(n / 120)) begin
                errors++;
                $display("FAIL frame_count_b n=%0d: got %0d, want %0d", n, b_fc, n / 120);
            end
`endif
        end
        checks++;
        if (hs_low_line0 !== 12) begin
            errors++;
            $display("FAIL hsync_width: low for %0d clks in line 0, want 12", hs_low_line0);
        end
        checks++;
        if (fs_count !== 3) begin
            errors++;
            $display("FAIL frame_starts: got %0d pulses, want 3", fs_count);
        end
        checks++;
        if (max_x !== 14) begin
            errors++;
            $display("FAIL max_xpixel: got %0d, want 14", max_x);
        end
    endtask

    // Reset for one clk at A position (5,2), then counting restarts from (0,0).
    task automatic test_mid_reset();
        int p, x, y;
        step(136);
        checks++;
        if (a_x !== 16'd5 || a_y !== 16'd2) begin
            errors++;
            $display("FAIL pre_reset_pos: a=(%0d,%0d), want (5,2)", a_x, a_y);
        end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checks++;
        if ({a_x, a_y} !== 32'd0 || a_video !== 1'b1 || a_hs !== 1'b1 || a_vs !== 1'b1 ||
            a_tick !== 1'b1 || a_fs !== 1'b0 || {b_x, b_y} !== 32'd0 || b_fs !== 1'b0 ||
            b_hs !== 1'b0 || b_vs !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: a=(%0d,%0d) v=%b hs=%b vs=%b tick=%b fs=%b b=(%0d,%0d) fs=%b, want zeros/reset levels",
                     a_x, a_y, a_video, a_hs, a_vs, a_tick, a_fs, b_x, b_y, b_fs);
        end
`ifdef VGA_FRAME_CNT_EN
        checks++;
        if (a_fc !== 16'd0 || b_fc !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset_fc: a=%0d b=%0d, want 0 0", a_fc, b_fc);
        end
`endif
        for (int n = 1; n <= 500; n++) begin
            step(1);
            p = n / 4;
            x = p % HT;
            y = (p / HT) % VT;
            checks++;
            if (a_x !== x[15:0] || a_y !== y[15:0] || a_fs !== (n == 480)) begin
                errors++;
                $display("FAIL resume_a n=%0d: (%0d,%0d) fs=%b, want (%0d,%0d) fs=%b",
                         n, a_x, a_y, a_fs, x, y, (n == 480));
            end
            x = n % HT;
            y = (n / HT) % VT;
            checks++;
            if (b_x !== x[15:0] || b_y !== y[15:0] || b_fs !== (n % 120 == 0)) begin
                errors++;
                $display("FAIL resume_b n=%0d: (%0d,%0d) fs=%b, want (%0d,%0d) fs=%b",
                         n, b_x, b_y, b_fs, x, y, (n % 120 == 0));
            end
        end
    endtask

    initial begin
        step(1);
        test_reset();
        test_free_run();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
